pixel_buffer_arbiter: RTL



---
 rtl/pixbuf_pkg.sv | 29 ++
 rtl/pixbuf_bank.sv | 57 +++++
 rtl/pixel_buffer_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pixbuf_pkg.sv
// Shared types and constants for the double-buffered pixel store.
// Build option: define PIXBUF_CLEAR_EN to add the one-edge back-bank clear.
package pixbuf_pkg;

  localparam int ROWS  = 32;
  localparam int COLS  = 32;
  localparam int PIX_W = 2;
  localparam int HALF  = 16;

  typedef logic [63:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SWAP,
    COPY,
    DONE
  } state_t;

  localparam logic [1:0] PIX_OFF   = 2'd0;
  localparam logic [1:0] PIX_BLUE  = 2'd1;
  localparam logic [1:0] PIX_RED   = 2'd2;
  localparam logic [1:0] PIX_WHITE = 2'd3;

  // Column 0 sits in the top bits of a row word, so column c starts at bit 62-2c.
  function automatic logic [5:0] pix_lsb(input logic [4:0] col);
    return 6'd62 - {col, 1'b0};
  endfunction

endpackage

// File: rtl/pixbuf_bank.sv
// One 32x64 pixel bank: pixel write, whole-row write, whole-bank clear,
// a row-pair read for the display and a single-row read for bank copies.
module pixbuf_bank
  import pixbuf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        pix_we,
  input  logic [4:0]  pix_row,
  input  logic [4:0]  pix_col,
  input  logic [1:0]  pix_val,
  input  logic        row_we,
  input  logic [4:0]  row_waddr,
  input  logic [63:0] row_wdata,
  input  logic [3:0]  pair_addr,
  output logic [63:0] pair_upper,
  output logic [63:0] pair_lower,
  input  logic [4:0]  rd_addr,
  output logic [63:0] rd_data
);

  row_t mem_q [ROWS];
  row_t mem_d [ROWS];

  // Next bank contents: clear first, then row copy, then the single-pixel update.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_d[r] = '0;
      end
    end
    if (row_we) begin
      mem_d[row_waddr] = row_wdata;
    end
    if (pix_we) begin
      mem_d[pix_row][pix_lsb(pix_col) +: PIX_W] = pix_val;
    end
  end

  // Bank storage with synchronous zeroing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign pair_upper = mem_q[{1'b0, pair_addr}];
  assign pair_lower = mem_q[{1'b1, pair_addr}];
  assign rd_data    = mem_q[rd_addr];

endmodule

// File: rtl/pixel_buffer_arbiter.sv
// Double-buffered 32x32x2 pixel store between the game writer and the HUB75
// scan reader. Commits swap banks at a frame boundary, then copy the new
// front into the new back so drawing continues from the shown board.
// Build option: define PIXBUF_CLEAR_EN to add the clr_req input.
module pixel_buffer_arbiter
  import pixbuf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [4:0]  wr_row,
  input  logic [4:0]  wr_col,
  input  logic [1:0]  wr_pix,
  output logic        wr_ack,
`ifdef PIXBUF_CLEAR_EN
  input  logic        clr_req,
`endif
  input  logic        commit_req,
  output logic        commit_ack,
  input  logic [4:0]  disp_raddr,
  input  logic        disp_ren,
  output logic [63:0] Hline,
  output logic [63:0] Lline,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] hline_q, hline_d;
  logic [63:0] lline_q, lline_d;
  logic        wr_ack_q, wr_ack_d;

  logic        clr_req_i;
  logic        at_boundary;
  logic        do_write;
  logic        do_clear;
  logic        do_copy;
  logic        do_swap;

  logic [63:0] bank_upper [2];
  logic [63:0] bank_lower [2];
  logic [63:0] bank_rd    [2];
  logic [63:0] front_upper;
  logic [63:0] front_lower;
  logic [63:0] front_rd;

`ifdef PIXBUF_CLEAR_EN
  assign clr_req_i = clr_req;
`else
  assign clr_req_i = 1'b0;
`endif

  assign at_boundary = !disp_ren && (disp_raddr == 5'd0);

  // The two physical banks; front_sel decides which one the display sees.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_back;
    assign is_back = (front_sel_q != 1'(b));

    pixbuf_bank u_bank (
      .clk        (clk),
      .rst        (rst),
      .clr        (is_back && do_clear),
      .pix_we     (is_back && do_write),
      .pix_row    (wr_row),
      .pix_col    (wr_col),
      .pix_val    (wr_pix),
      .row_we     (is_back && do_copy),
      .row_waddr  (cnt_q),
      .row_wdata  (front_rd),
      .pair_addr  (disp_raddr[3:0]),
      .pair_upper (bank_upper[b]),
      .pair_lower (bank_lower[b]),
      .rd_addr    (cnt_q),
      .rd_data    (bank_rd[b])
    );
  end

  assign front_upper = front_sel_q ? bank_upper[1] : bank_upper[0];
  assign front_lower = front_sel_q ? bank_lower[1] : bank_lower[0];
  assign front_rd    = front_sel_q ? bank_rd[1]    : bank_rd[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: commit waits for the scan to sit idle at row pair 0, then copies 32 rows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (commit_req)        state_d = WAIT_SWAP;
      WAIT_SWAP: if (at_boundary)       state_d = COPY;
      COPY:      if (cnt_q == 5'd31)    state_d = DONE;
      DONE:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // FSM outputs: writer access only in IDLE, clear beats a pending pixel write.
  always_comb begin
    do_clear   = (state_q == IDLE) && clr_req_i;
    do_write   = (state_q == IDLE) && wr_req && !clr_req_i;
    do_copy    = (state_q == COPY);
    do_swap    = (state_q == WAIT_SWAP) && at_boundary;
    busy       = (state_q == WAIT_SWAP) || (state_q == COPY);
    commit_ack = (state_q == DONE);
  end

  // Datapath next values: bank select, copy counter, display lines and write ack.
  always_comb begin
    front_sel_d = front_sel_q ^ do_swap;
    cnt_d       = cnt_q;
    if (do_swap) begin
      cnt_d = 5'd0;
    end else if (do_copy) begin
      cnt_d = cnt_q + 5'd1;
    end
    hline_d  = disp_ren ? front_upper : hline_q;
    lline_d  = disp_ren ? front_lower : lline_q;
    wr_ack_d = do_write || do_clear;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel_q <= 1'b0;
      cnt_q       <= 5'd0;
      hline_q     <= '0;
      lline_q     <= '0;
      wr_ack_q    <= 1'b0;
    end else begin
      front_sel_q <= front_sel_d;
      cnt_q       <= cnt_d;
      hline_q     <= hline_d;
      lline_q     <= lline_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  assign wr_ack = wr_ack_q;
  assign Hline  = hline_q;
  assign Lline  = lline_q;

endmodule
